// File: rtl/ram_2port_pkg.sv
// Shared types and constants for the 2-port RAM test path (write and read controllers).
package ram_2port_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 6;
   localparam int DEPTH_DEF  = 64;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_GAP   = 3'd2,
      ST_READ  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Fibonacci LFSR x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3, shifted in at bit 0.
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ram_wr_pattern_gen.sv
// Write-data pattern source: seed+addr counter by default, 8-bit LFSR when RAM_WR_LFSR_EN is defined.
module ram_wr_pattern_gen
   import ram_2port_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_seed,
   input  logic              i_load,
   input  logic              i_step,
   input  logic              i_clear,
   output logic [DATA_W-1:0] o_data
);

   logic [DATA_W-1:0] r_val;
   logic [DATA_W-1:0] w_load_val;
   logic [DATA_W-1:0] w_next_val;

`ifdef RAM_WR_LFSR_EN
   if (DATA_W != 8) begin : g_width_chk
      $error("ram_wr_pattern_gen: LFSR pattern requires DATA_W == 8");
   end
   assign w_load_val = LFSR_SEED ^ i_seed;
   assign w_next_val = {r_val[DATA_W-2:0], ^(r_val & LFSR_TAPS)};
`else
   assign w_load_val = i_seed;
   assign w_next_val = r_val + 1'b1;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_val <= '0;
      end else if (i_load) begin
         r_val <= w_load_val;
      end else if (i_step) begin
         r_val <= w_next_val;
      end
   end

   assign o_data = r_val;

endmodule

// File: rtl/ram_wr.sv
// RAM write-side controller: fill pass, guard gap, read window, done pulse; optional auto-loop.
// Data pattern selected by macro RAM_WR_LFSR_EN (undefined: seed+addr incrementing pattern).
//
// state    | meaning
// ST_IDLE  | waiting for start, outputs low
// ST_WRITE | one RAM word per cycle, addr 0..DEPTH-1
// ST_GAP   | guard cycles between last write and read window
// ST_READ  | rd_flag held high for RD_CYC cycles
// ST_DONE  | one-cycle done pulse; loop selects WRITE or IDLE
module ram_wr
   import ram_2port_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int GAP_CYC = 1,
   parameter int RD_CYC  = 66
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_loop,
   output logic              o_ram_wr_en,
   output logic [ADDR_W-1:0] o_ram_wr_addr,
   output logic [DATA_W-1:0] o_ram_wr_data,
   output logic              o_rd_flag,
   output logic              o_busy,
   output logic              o_done,
   output logic [7:0]        o_pass_cnt
);

   localparam int CNT_W = $clog2(max3(DEPTH, RD_CYC, GAP_CYC) + 1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic              r_rd_flag;
   logic              r_busy;
   logic              r_done;
   logic [7:0]        r_pass_cnt;
   logic [DATA_W-1:0] r_seed;

   logic w_wr_last;
   logic w_gap_last;
   logic w_rd_last;
   logic w_enter_wr;
   logic w_step;

   assign w_wr_last  = (r_state == ST_WRITE) && (r_cnt == CNT_W'(DEPTH - 1));
   assign w_gap_last = (r_state == ST_GAP)   && (r_cnt == CNT_W'(GAP_CYC - 1));
   assign w_rd_last  = (r_state == ST_READ)  && (r_cnt == CNT_W'(RD_CYC - 1));
   assign w_enter_wr = ((r_state == ST_IDLE) && i_start) || ((r_state == ST_DONE) && i_loop);
   assign w_step     = (r_state == ST_WRITE) && !w_wr_last;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_rd_flag  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass_cnt <= '0;
         r_seed     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state   <= ST_WRITE;
                  r_cnt     <= '0;
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= '0;
                  r_busy    <= 1'b1;
               end
            end
            ST_WRITE: begin
               if (w_wr_last) begin
                  r_state   <= ST_GAP;
                  r_cnt     <= '0;
                  r_wr_en   <= 1'b0;
                  r_wr_addr <= '0;
               end else begin
                  r_cnt     <= r_cnt + 1'b1;
                  r_wr_addr <= r_wr_addr + 1'b1;
               end
            end
            ST_GAP: begin
               if (w_gap_last) begin
                  r_state   <= ST_READ;
                  r_cnt     <= '0;
                  r_rd_flag <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_READ: begin
               if (w_rd_last) begin
                  r_state    <= ST_DONE;
                  r_cnt      <= '0;
                  r_rd_flag  <= 1'b0;
                  r_done     <= 1'b1;
                  r_pass_cnt <= r_pass_cnt + 8'd1;
                  r_seed     <= r_seed + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               // seed was advanced on DONE entry, so a looped pass loads the new seed
               if (i_loop) begin
                  r_state   <= ST_WRITE;
                  r_cnt     <= '0;
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= '0;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   ram_wr_pattern_gen #(
      .DATA_W (DATA_W)
   ) u_pattern_gen (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_seed  (r_seed),
      .i_load  (w_enter_wr),
      .i_step  (w_step),
      .i_clear (w_wr_last),
      .o_data  (o_ram_wr_data)
   );

   assign o_ram_wr_en   = r_wr_en;
   assign o_ram_wr_addr = r_wr_addr;
   assign o_rd_flag     = r_rd_flag;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_pass_cnt    = r_pass_cnt;

endmodule

// File: tb/tb_ram_wr.sv
// Self-checking bench for ram_wr: single passes, ignored starts, mid-pass reset, looping with wraps.
module tb_ram_wr;

   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 6;
   localparam int DEPTH    = 64;
   localparam int GAP_CYC  = 1;
   localparam int RD_CYC   = 66;
   localparam int PASS_LEN = DEPTH + GAP_CYC + RD_CYC + 1;

   logic              clk = 1'b0;
   logic              i_rst = 1'b1;
   logic              i_start = 1'b0;
   logic              i_loop = 1'b0;
   logic              o_ram_wr_en;
   logic [ADDR_W-1:0] o_ram_wr_addr;
   logic [DATA_W-1:0] o_ram_wr_data;
   logic              o_rd_flag;
   logic              o_busy;
   logic              o_done;
   logic [7:0]        o_pass_cnt;

   int checks = 0;
   int failures = 0;

   logic [7:0] mem [DEPTH];

   typedef struct {
      int          cyc;
      logic [17:0] exp;
   } vec_t;
   vec_t tbl [7];

   ram_wr #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH),
      .GAP_CYC (GAP_CYC),
      .RD_CYC  (RD_CYC)
   ) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_start       (i_start),
      .i_loop        (i_loop),
      .o_ram_wr_en   (o_ram_wr_en),
      .o_ram_wr_addr (o_ram_wr_addr),
      .o_ram_wr_data (o_ram_wr_data),
      .o_rd_flag     (o_rd_flag),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_pass_cnt    (o_pass_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (o_ram_wr_en) mem[o_ram_wr_addr] <= o_ram_wr_data;
   end

   wire [17:0] w_got = {o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_rd_flag, o_busy, o_done};

   function automatic logic [7:0] pat(input int seed, input int idx);
`ifdef RAM_WR_LFSR_EN
      logic [7:0] r;
      r = 8'hA5 ^ 8'(seed);
      for (int i = 0; i < idx; i++) r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
      return r;
`else
      return 8'(seed + idx);
`endif
   endfunction

   function automatic logic [17:0] pack(input bit wr, input int addr, input logic [7:0] data,
                                        input bit rd, input bit busy, input bit done);
      return {wr, 6'(addr), data, rd, busy, done};
   endfunction

   // expected outputs c cycles after the edge that accepted start (c=1 is the first write)
   function automatic logic [17:0] exp_out(input int c, input int seed);
      if (c < 1) return '0;
      if (c <= DEPTH) return pack(1'b1, c - 1, pat(seed, c - 1), 1'b0, 1'b1, 1'b0);
      if (c <= DEPTH + GAP_CYC) return pack(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);
      if (c <= DEPTH + GAP_CYC + RD_CYC) return pack(1'b0, 0, 8'h00, 1'b1, 1'b1, 1'b0);
      if (c == PASS_LEN) return pack(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b1);
      return '0;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic run_pass(input string name, input int seed, input int exp_cnt, input bit poke);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      for (int c = 1; c <= PASS_LEN + 1; c++) begin
         foreach (tbl[i]) if (tbl[i].cyc == c && seed == 0) check({name, "_table"}, 32'(w_got), 32'(tbl[i].exp));
         check(name, 32'(w_got), 32'(exp_out(c, seed)));
         if (c == PASS_LEN) check({name, "_pass_cnt"}, 32'(o_pass_cnt), 32'(exp_cnt));
         i_start = poke && (c == 10 || c == 80);
         @(negedge clk);
      end
      i_start = 1'b0;
   endtask

   initial begin
      tbl[0] = '{1,        pack(1'b1, 0,  pat(0, 0),  1'b0, 1'b1, 1'b0)};
      tbl[1] = '{DEPTH,    pack(1'b1, 63, pat(0, 63), 1'b0, 1'b1, 1'b0)};
      tbl[2] = '{DEPTH+1,  pack(1'b0, 0,  8'h00,      1'b0, 1'b1, 1'b0)};
      tbl[3] = '{DEPTH+2,  pack(1'b0, 0,  8'h00,      1'b1, 1'b1, 1'b0)};
      tbl[4] = '{PASS_LEN-1, pack(1'b0, 0, 8'h00,     1'b1, 1'b1, 1'b0)};
      tbl[5] = '{PASS_LEN, pack(1'b0, 0,  8'h00,      1'b0, 1'b1, 1'b1)};
      tbl[6] = '{PASS_LEN+1, pack(1'b0, 0, 8'h00,     1'b0, 1'b0, 1'b0)};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 32'(w_got), 32'd0);
      check("reset_pass_cnt", 32'(o_pass_cnt), 32'd0);
      i_rst = 1'b0;
      @(negedge clk);

      run_pass("pass1", 0, 1, 1'b0);
      run_pass("pass2_ignored_start", 1, 2, 1'b0 | 1'b1);
      check("ram_addr0", 32'(mem[0]), 32'(pat(1, 0)));
      check("ram_addr31", 32'(mem[31]), 32'(pat(1, 31)));
      check("ram_addr63", 32'(mem[63]), 32'(pat(1, 63)));

      // reset mid-WRITE around addr 20
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (19) @(negedge clk);
      check("midpass_addr", 32'(o_ram_wr_addr), 32'd19);
      i_rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("midreset_outputs", 32'(w_got), 32'd0);
         check("midreset_pass_cnt", 32'(o_pass_cnt), 32'd0);
      end
      i_rst = 1'b0;
      repeat (2) @(negedge clk);
      check("post_reset_idle", 32'(w_got), 32'd0);

      // 256 back-to-back passes: seed and pass_cnt both wrap
      i_loop = 1'b1;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      for (int p = 0; p < 256; p++) begin
         for (int c = 1; c <= PASS_LEN; c++) begin
            check("loop", 32'(w_got), 32'(exp_out(c, p & 255)));
            if (c == PASS_LEN) check("loop_pass_cnt", 32'(o_pass_cnt), 32'((p + 1) & 255));
            if (p == 255 && c == 100) i_loop = 1'b0;
            @(negedge clk);
         end
      end
      check("loop_end_idle", 32'(w_got), 32'd0);
      check("loop_end_pass_cnt", 32'(o_pass_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
